// File: rtl/mem_cmd_issuer.sv
// Command FIFO in front of a memory_core: queues write/read commands, issues the
// head entry on enabled cycles and returns read data one enabled cycle later.
module mem_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clk_en,
  input  logic                       flush,
  input  logic                       cmd_valid,
  input  logic [33:0]                cmd,
  output logic                       cmd_ready,
  output logic                       wen_out,
  output logic                       ren_out,
  output logic [15:0]                addr_out,
  output logic [15:0]                wdata_out,
  input  logic [15:0]                core_rdata,
  output logic                       rsp_valid,
  output logic [15:0]                rsp_data,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           issued_cnt,
  output logic                       err_both
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef struct packed {
    logic        wen;
    logic        ren;
    logic [15:0] data;
    logic [15:0] addr;
  } entry_t;

  entry_t fifo_mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    count_q, count_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;
  logic             err_both_q, err_both_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;

  logic   full;
  logic   accept;
  logic   push;
  logic   pop;
  entry_t push_entry;
  entry_t head;

  // Gating with rst_n keeps cmd_ready low while reset is held.
  assign full      = (count_q == OW'(DEPTH));
  assign cmd_ready = rst_n & ~full & ~flush;
  assign accept    = cmd_valid & cmd_ready;
  assign push      = accept & (cmd[33] | cmd[32]);
  assign pop       = clk_en & ~flush & (count_q != '0);
  assign head      = fifo_mem[rd_ptr_q];

  always_comb begin
    push_entry.wen  = cmd[33];
    push_entry.ren  = cmd[32] & ~cmd[33];
    push_entry.data = cmd[31:16];
    push_entry.addr = cmd[15:0];
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pending_d    = pending_q;
    issued_cnt_d = issued_cnt_q;
    err_both_d   = err_both_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + AW'(1);
      issued_cnt_d = issued_cnt_q + CNT_W'(1);
      addr_d       = head.addr;
      wdata_d      = head.data;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + OW'(1);
      2'b01:   count_d = count_q - OW'(1);
      default: count_d = count_q;
    endcase

    // The pending flag only advances on enabled cycles so disabled gaps stretch latency.
    if (flush) begin
      pending_d = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end else if (clk_en) begin
      pending_d = pop & head.ren;
    end

    if (accept && cmd[33] && cmd[32]) begin
      err_both_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pending_q    <= 1'b0;
      issued_cnt_q <= '0;
      err_both_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      issued_cnt_q <= issued_cnt_d;
      err_both_q   <= err_both_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_entry;
    end
  end

  assign wen_out    = pop & head.wen;
  assign ren_out    = pop & head.ren;
  assign addr_out   = pop ? head.addr : addr_q;
  assign wdata_out  = pop ? head.data : wdata_q;
  assign rsp_valid  = pending_q & clk_en;
  assign rsp_data   = core_rdata;
  assign occupancy  = count_q;
  assign issued_cnt = issued_cnt_q;
  assign err_both   = err_both_q;

endmodule

// File: tb/tb_mem_cmd_issuer.sv
// Directed bench for mem_cmd_issuer with a small behavioural memory_core
// (one-enabled-cycle read latency) supplying core_rdata.
module tb_mem_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        flush;
  logic        cmd_valid;
  logic [33:0] cmd;
  logic        cmd_ready;
  logic        wen_out;
  logic        ren_out;
  logic [15:0] addr_out;
  logic [15:0] wdata_out;
  logic [15:0] core_rdata = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [2:0]  occupancy;
  logic [15:0] issued_cnt;
  logic        err_both;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_cmd_issuer #(.DEPTH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .flush      (flush),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_ready  (cmd_ready),
    .wen_out    (wen_out),
    .ren_out    (ren_out),
    .addr_out   (addr_out),
    .wdata_out  (wdata_out),
    .core_rdata (core_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .occupancy  (occupancy),
    .issued_cnt (issued_cnt),
    .err_both   (err_both)
  );

  // Unwritten locations read back as 0x1000 + low address byte.
  logic [15:0] mem [256];
  bit          written [256];

  always @(posedge clk) begin
    if (clk_en) begin
      if (wen_out) begin
        mem[addr_out[7:0]]     <= wdata_out;
        written[addr_out[7:0]] <= 1'b1;
      end
      if (ren_out) begin
        core_rdata <= written[addr_out[7:0]] ? mem[addr_out[7:0]]
                                             : (16'h1000 + {8'h00, addr_out[7:0]});
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %h t=%0t", tag, got, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [33:0] wr(input logic [15:0] a, input logic [15:0] d);
    return {2'b10, d, a};
  endfunction

  function automatic logic [33:0] rd(input logic [15:0] a);
    return {2'b01, 16'h0000, a};
  endfunction

  initial begin
    rst_n = 1'b0; clk_en = 1'b0; flush = 1'b0; cmd_valid = 1'b0; cmd = '0;
    #2;
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_wen", 32'(wen_out), 32'd0);
    chk("rst_ren", 32'(ren_out), 32'd0);
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_addr", 32'(addr_out), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_cnt", 32'(issued_cnt), 32'd0);
    chk("rst_err", 32'(err_both), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // write 0xBEEF @0x0010 then read it back
    clk_en = 1'b1; cmd_valid = 1'b1; cmd = wr(16'h0010, 16'hBEEF);
    #2; chk("wr_ready", 32'(cmd_ready), 32'd1); chk("wr_empty_wen", 32'(wen_out), 32'd0);
    tick();
    cmd = rd(16'h0010);
    #2; chk("wr_wen", 32'(wen_out), 32'd1); chk("wr_ren", 32'(ren_out), 32'd0);
    chk("wr_addr", 32'(addr_out), 32'h0010); chk("wr_data", 32'(wdata_out), 32'hBEEF);
    tick();
    cmd_valid = 1'b0; cmd = '0;
    #2; chk("rd_ren", 32'(ren_out), 32'd1); chk("rd_addr", 32'(addr_out), 32'h0010);
    chk("rd_rsp_early", 32'(rsp_valid), 32'd0);
    tick();
    #2; chk("rd_rsp", 32'(rsp_valid), 32'd1); chk("rd_data", 32'(rsp_data), 32'hBEEF);
    chk("rd_cnt", 32'(issued_cnt), 32'd2); chk("rd_idle", 32'(ren_out), 32'd0);
    tick();
    #2; chk("rd_rsp_once", 32'(rsp_valid), 32'd0); chk("addr_hold", 32'(addr_out), 32'h0010);
    tick();

    // fill with clk_en low, then drain
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd = rd(16'h0020 + 16'(i));
      #2; chk($sformatf("fill_ready%0d", i), 32'(cmd_ready), 32'd1);
      tick();
    end
    cmd = wr(16'h0030, 16'hDEAD);
    #2; chk("full_occ", 32'(occupancy), 32'd4); chk("full_ready", 32'(cmd_ready), 32'd0);
    chk("full_hold", 32'(ren_out), 32'd0);
    tick();
    clk_en = 1'b1;
    #2; chk("full_pop_ready", 32'(cmd_ready), 32'd0); chk("drain_ren0", 32'(ren_out), 32'd1);
    chk("drain_addr0", 32'(addr_out), 32'h0020);
    tick();
    cmd_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      #2;
      chk($sformatf("drain_ren%0d", i), 32'(ren_out), 32'd1);
      chk($sformatf("drain_addr%0d", i), 32'(addr_out), 32'h0020 + i);
      chk($sformatf("drain_rsp%0d", i - 1), 32'(rsp_valid), 32'd1);
      chk($sformatf("drain_data%0d", i - 1), 32'(rsp_data), 32'h1020 + i - 1);
      tick();
    end
    #2; chk("drain_end_ren", 32'(ren_out), 32'd0); chk("drain_no_wen", 32'(wen_out), 32'd0);
    chk("drain_rsp3", 32'(rsp_valid), 32'd1); chk("drain_data3", 32'(rsp_data), 32'h1023);
    chk("drain_occ", 32'(occupancy), 32'd0);
    tick();
    #2; chk("drain_rsp_end", 32'(rsp_valid), 32'd0); chk("drain_cnt", 32'(issued_cnt), 32'd6);
    tick();

    // read then three disabled cycles
    cmd_valid = 1'b1; cmd = rd(16'h0040);
    #2; tick();
    cmd_valid = 1'b0;
    #2; chk("stall_ren", 32'(ren_out), 32'd1);
    tick();
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2; chk($sformatf("stall_rsp%0d", i), 32'(rsp_valid), 32'd0);
      tick();
    end
    clk_en = 1'b1;
    #2; chk("stall_rsp_on", 32'(rsp_valid), 32'd1); chk("stall_data", 32'(rsp_data), 32'h1040);
    tick();
    #2; chk("stall_rsp_off", 32'(rsp_valid), 32'd0); chk("stall_cnt", 32'(issued_cnt), 32'd7);
    tick();

    // wen+ren both set, then neither set
    cmd_valid = 1'b1; cmd = {2'b11, 16'h1234, 16'h0050};
    #2; tick();
    cmd = {2'b00, 16'h5555, 16'h0051};
    #2; chk("both_wen", 32'(wen_out), 32'd1); chk("both_ren", 32'(ren_out), 32'd0);
    chk("both_addr", 32'(addr_out), 32'h0050); chk("both_data", 32'(wdata_out), 32'h1234);
    chk("drop_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    #2; chk("drop_wen", 32'(wen_out), 32'd0); chk("drop_ren", 32'(ren_out), 32'd0);
    chk("drop_rsp", 32'(rsp_valid), 32'd0); chk("drop_occ", 32'(occupancy), 32'd0);
    chk("both_err", 32'(err_both), 32'd1);
    tick();
    #2; chk("both_rsp", 32'(rsp_valid), 32'd0); chk("both_cnt", 32'(issued_cnt), 32'd8);
    tick();

    // flush with occupancy 3 and a read pending
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd = rd(16'h0060 + 16'(i));
      tick();
    end
    cmd_valid = 1'b0; clk_en = 1'b1;
    #2; chk("fl_ren", 32'(ren_out), 32'd1); chk("fl_addr", 32'(addr_out), 32'h0060);
    tick();
    flush = 1'b1;
    #2; chk("fl_occ3", 32'(occupancy), 32'd3); chk("fl_no_issue", 32'(ren_out), 32'd0);
    chk("fl_ready", 32'(cmd_ready), 32'd0);
    tick();
    flush = 1'b0;
    #2; chk("fl_occ0", 32'(occupancy), 32'd0); chk("fl_rsp", 32'(rsp_valid), 32'd0);
    chk("fl_ren_after", 32'(ren_out), 32'd0); chk("fl_cnt", 32'(issued_cnt), 32'd9);
    chk("fl_err", 32'(err_both), 32'd1);
    tick();
    #2; chk("fl_ren_after2", 32'(ren_out), 32'd0); chk("fl_rsp2", 32'(rsp_valid), 32'd0);
    tick();

    // asynchronous reset mid-burst
    clk_en = 1'b0;
    cmd_valid = 1'b1; cmd = rd(16'h0070); tick();
    cmd = rd(16'h0071); tick();
    cmd = wr(16'h0072, 16'h7777); tick();
    cmd_valid = 1'b0; clk_en = 1'b1;
    #2; chk("ar_ren", 32'(ren_out), 32'd1); chk("ar_addr", 32'(addr_out), 32'h0070);
    tick();
    #2; rst_n = 1'b0;
    #1;
    chk("ar_ready", 32'(cmd_ready), 32'd0); chk("ar_ren0", 32'(ren_out), 32'd0);
    chk("ar_wen0", 32'(wen_out), 32'd0); chk("ar_rsp0", 32'(rsp_valid), 32'd0);
    chk("ar_occ0", 32'(occupancy), 32'd0); chk("ar_cnt0", 32'(issued_cnt), 32'd0);
    chk("ar_err0", 32'(err_both), 32'd0); chk("ar_addr0", 32'(addr_out), 32'd0);
    chk("ar_wdata0", 32'(wdata_out), 32'd0);
    tick();
    #2; rst_n = 1'b1;
    tick();
    cmd_valid = 1'b1; cmd = wr(16'h0080, 16'hCAFE);
    #2; chk("post_ready", 32'(cmd_ready), 32'd1); chk("post_empty", 32'(ren_out | wen_out), 32'd0);
    tick();
    cmd = rd(16'h0080);
    #2; chk("post_wen", 32'(wen_out), 32'd1); chk("post_addr", 32'(addr_out), 32'h0080);
    chk("post_wdata", 32'(wdata_out), 32'hCAFE);
    tick();
    cmd_valid = 1'b0;
    #2; chk("post_ren", 32'(ren_out), 32'd1); chk("post_raddr", 32'(addr_out), 32'h0080);
    tick();
    #2; chk("post_rsp", 32'(rsp_valid), 32'd1); chk("post_data", 32'(rsp_data), 32'hCAFE);
    chk("post_cnt", 32'(issued_cnt), 32'd2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
